// File: rtl/seg7_scan_out.sv
// Bus-writable eight-digit common-anode 7-segment scanner with register readback.
// A prescaler advances the digit counter; anode and segment pins are registered together.
module seg7_scan_out #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        segclk,
  input  logic        segrst,
  input  logic        segaddrcs,
  input  logic        segwrite,
  input  logic        segread,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [15:0] segrdata,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  digit_q, digit_d;
  logic [15:0] data_lo_q, data_lo_d;
  logic [15:0] data_hi_q, data_hi_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  an_q, an_d;

  logic        presc_wrap;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_all;
  logic [3:0]  nibble;
  logic [15:0] rd_mux;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_wrap = (presc_q == DIV_LAST);
    presc_d    = presc_wrap ? '0 : presc_q + 16'd1;
    digit_d    = presc_wrap ? digit_q + 3'd1 : digit_q;

    wr_en = segaddrcs && segwrite;
    rd_en = segaddrcs && segread;

    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    ctrl_d    = ctrl_q;
    if (wr_en) begin
      case (segaddr)
        2'd0:    data_lo_d = segwdata;
        2'd1:    data_hi_d = segwdata;
        2'd2:    ctrl_d    = segwdata;
        default: ;
      endcase
    end

    // Readback uses pre-write register values, so a same-edge read returns the old data.
    case (segaddr)
      2'd0:    rd_mux = data_lo_q;
      2'd1:    rd_mux = data_hi_q;
      2'd2:    rd_mux = ctrl_q;
      default: rd_mux = '0;
    endcase
    rdata_d = rd_en ? rd_mux : rdata_q;

    data_all = {data_hi_q, data_lo_q};
    nibble   = data_all[{digit_q, 2'b00} +: 4];
    seg_d    = {~ctrl_q[{1'b1, digit_q}], hex7(nibble)};
    an_d     = ctrl_q[{1'b0, digit_q}] ? ~(8'h01 << digit_q) : '1;
  end

  always_ff @(posedge segclk) begin
    if (segrst) begin
      presc_q   <= '0;
      digit_q   <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
      ctrl_q    <= 16'h00FF;
      rdata_q   <= '0;
      seg_q     <= '1;
      an_q      <= '1;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign segrdata = rdata_q;
  assign seg_o    = seg_q;
  assign an_o     = an_q;

endmodule

// File: tb/tb_seg7_scan_out.sv
// Randomized and directed bench for seg7_scan_out against a time-based reference model.
module tb_seg7_scan_out;

  localparam int unsigned DIV = 4;

  logic        segclk = 1'b0;
  logic        segrst;
  logic        segaddrcs;
  logic        segwrite;
  logic        segread;
  logic [1:0]  segaddr;
  logic [15:0] segwdata;
  logic [15:0] segrdata;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;

  seg7_scan_out #(.SCAN_DIV(DIV)) dut (
    .segclk    (segclk),
    .segrst    (segrst),
    .segaddrcs (segaddrcs),
    .segwrite  (segwrite),
    .segread   (segread),
    .segaddr   (segaddr),
    .segwdata  (segwdata),
    .segrdata  (segrdata),
    .seg_o     (seg_o),
    .an_o      (an_o)
  );

  always #5 segclk = ~segclk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [6:0]  seg_lut [16];
  logic [15:0] m_regs [3];
  logic [15:0] m_rdata;
  int unsigned k;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from the model, clock the DUT, compare all outputs.
  task automatic tick();
    logic [7:0]  e_seg;
    logic [7:0]  e_an;
    logic [31:0] data;
    logic [3:0]  nib;
    int unsigned d;
    if (segrst) begin
      m_regs[0] = 16'h0000;
      m_regs[1] = 16'h0000;
      m_regs[2] = 16'h00FF;
      m_rdata   = 16'h0000;
      k         = 0;
      e_seg     = 8'hFF;
      e_an      = 8'hFF;
    end else begin
      d     = (k / DIV) % 8;
      k++;
      data  = {m_regs[1], m_regs[0]};
      nib   = 4'((data >> (4 * d)) & 32'hF);
      e_an  = m_regs[2][d] ? 8'(~(32'd1 << d)) : 8'hFF;
      e_seg = {~m_regs[2][8 + d], seg_lut[nib]};
      if (segaddrcs && segread)
        m_rdata = (segaddr == 2'd3) ? 16'h0000 : m_regs[segaddr];
      if (segaddrcs && segwrite && segaddr != 2'd3)
        m_regs[segaddr] = segwdata;
    end
    @(posedge segclk);
    #1;
    chk("seg_o", {8'h00, seg_o}, {8'h00, e_seg});
    chk("an_o", {8'h00, an_o}, {8'h00, e_an});
    chk("segrdata", segrdata, m_rdata);
  endtask

  task automatic idle_inputs();
    segaddrcs = 1'b0;
    segwrite  = 1'b0;
    segread   = 1'b0;
    segaddr   = 2'd0;
    segwdata  = 16'h0000;
  endtask

  task automatic bus(input logic cs, input logic wr, input logic rd,
                     input logic [1:0] addr, input logic [15:0] wd);
    segaddrcs = cs;
    segwrite  = wr;
    segread   = rd;
    segaddr   = addr;
    segwdata  = wd;
    tick();
    idle_inputs();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    seg_lut[0]  = 7'h40; seg_lut[1]  = 7'h79; seg_lut[2]  = 7'h24; seg_lut[3]  = 7'h30;
    seg_lut[4]  = 7'h19; seg_lut[5]  = 7'h12; seg_lut[6]  = 7'h02; seg_lut[7]  = 7'h78;
    seg_lut[8]  = 7'h00; seg_lut[9]  = 7'h10; seg_lut[10] = 7'h08; seg_lut[11] = 7'h03;
    seg_lut[12] = 7'h46; seg_lut[13] = 7'h21; seg_lut[14] = 7'h06; seg_lut[15] = 7'h0E;
    m_regs[0] = 16'h0000;
    m_regs[1] = 16'h0000;
    m_regs[2] = 16'h00FF;
    m_rdata   = 16'h0000;
    k         = 0;

    idle_inputs();
    segrst = 1'b1;
    #1;
    tick();
    tick();
    segrst = 1'b0;
    run(8 * DIV + 4);

    bus(1'b1, 1'b1, 1'b0, 2'd0, 16'h3210);
    bus(1'b1, 1'b1, 1'b0, 2'd1, 16'hFEDC);
    bus(1'b1, 1'b1, 1'b0, 2'd2, 16'h00FF);
    run(8 * DIV + 2);

    bus(1'b1, 1'b1, 1'b0, 2'd2, 16'h0F05);
    run(8 * DIV + 2);

    bus(1'b1, 1'b0, 1'b1, 2'd0, 16'h0000);
    chk("rd_lo", segrdata, 16'h3210);
    bus(1'b1, 1'b0, 1'b1, 2'd1, 16'h0000);
    chk("rd_hi", segrdata, 16'hFEDC);
    bus(1'b1, 1'b0, 1'b1, 2'd2, 16'h0000);
    chk("rd_ctrl", segrdata, 16'h0F05);
    bus(1'b1, 1'b0, 1'b1, 2'd3, 16'h0000);
    chk("rd_rsvd", segrdata, 16'h0000);
    bus(1'b1, 1'b0, 1'b1, 2'd1, 16'h0000);
    bus(1'b0, 1'b0, 1'b1, 2'd0, 16'h0000);
    chk("rd_nocs", segrdata, 16'hFEDC);

    bus(1'b1, 1'b1, 1'b1, 2'd0, 16'hABCD);
    chk("rd_wr_old", segrdata, 16'h3210);
    bus(1'b1, 1'b1, 1'b0, 2'd0, 16'h3210);

    bus(1'b0, 1'b1, 1'b0, 2'd0, 16'h1111);
    bus(1'b1, 1'b1, 1'b0, 2'd3, 16'h2222);
    run(8 * DIV + 2);

    while (((k / DIV) % 8) != 5) tick();
    tick();
    segrst = 1'b1;
    bus(1'b1, 1'b1, 1'b0, 2'd2, 16'hFF00);
    segrst = 1'b0;
    chk("rst_an", {8'h00, an_o}, 16'h00FF);
    tick();
    chk("post_rst_an", {8'h00, an_o}, 16'h00FE);
    chk("post_rst_seg", {8'h00, seg_o}, 16'h00C0);
    run(2 * DIV);

    for (int unsigned i = 0; i < 4000; i++) begin
      segrst    = ($urandom_range(0, 299) == 0);
      segaddrcs = 1'($urandom_range(0, 1));
      segwrite  = ($urandom_range(0, 5) == 0);
      segread   = ($urandom_range(0, 2) == 0);
      segaddr   = 2'($urandom_range(0, 3));
      segwdata  = 16'($urandom);
      tick();
    end
    segrst = 1'b0;
    idle_inputs();
    run(8 * DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
